// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   - segment patterns (a..g on bits 6..0, active-high) for 0..9, dash, blank
//   - scan FSM state encoding
//   - digit count and internal dwell/gap counter width
//   - helper that turns a digit index into its one-hot digit select
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Wide enough for DWELL_CYCLES-1 up to 2^20-1 and GAP_CYCLES-1 up to 254.
    localparam int CNT_W = 20;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } state_t;

    // Digit 0 is the leftmost digit and is selected by 4'b1000.
    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD nibble to 7-segment pattern decoder.
// Values 0..9 give the standard digit shapes; A..F show a dash so the display
// never shows garbage and the output is never X.
//
// Ports:
//   bcd   in  4  nibble to decode
//   segs  out 7  segments a..g on bits 6..0, active-high
// -----------------------------------------------------------------------------
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segs
);

    always_comb begin
        segs = SEG_DASH;
        case (bcd)
            4'd0:    segs = SEG_0;
            4'd1:    segs = SEG_1;
            4'd2:    segs = SEG_2;
            4'd3:    segs = SEG_3;
            4'd4:    segs = SEG_4;
            4'd5:    segs = SEG_5;
            4'd6:    segs = SEG_6;
            4'd7:    segs = SEG_7;
            4'd8:    segs = SEG_8;
            4'd9:    segs = SEG_9;
            default: segs = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-select 7-segment
// display. Each digit is driven for DWELL_CYCLES clocks, followed by
// GAP_CYCLES all-off clocks to suppress ghosting. A new 16-bit BCD value is
// accepted into a one-entry pending buffer and only moved into the display
// register at a frame boundary (or immediately while idle), so every frame
// shows one consistent value.
//
// Optional build macro:
//   SEG_SCAN_LZB_EN  leading-zero blanking on digits 0..2 (digit 3 always shown)
//
// Parameters:
//   DWELL_CYCLES  clocks per digit visit (2..2^20)
//   GAP_CYCLES    blank clocks after each digit (1..255)
//
// Ports:
//   CLK         in   1  clock, rising edge
//   RST_N       in   1  asynchronous active-low reset
//   ENABLE      in   1  scan enable (level)
//   LOAD_VALID  in   1  new display value offered
//   LOAD_DATA   in  16  four BCD nibbles, [15:12] = leftmost digit
//   LOAD_READY  out  1  pending buffer empty; load taken this cycle if valid
//   CODEOUT     out  7  segments a..g on bits 6..0, active-high
//   SEG         out  4  one-hot digit select, 4'b1000 = leftmost digit
//   FRAME_DONE  out  1  one-cycle pulse during the last gap cycle of digit 3
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int GAP_CYCLES   = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic        LOAD_VALID,
    input  logic [15:0] LOAD_DATA,
    output logic        LOAD_READY,
    output logic [6:0]  CODEOUT,
    output logic [3:0]  SEG,
    output logic        FRAME_DONE
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

    state_t           state, state_n;
    logic [1:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]      disp, disp_n;
    logic [15:0]      pend;
    logic             pend_vld, pend_vld_n;

    logic             accept;
    logic             copy;
    logic [3:0]       nib;
    logic [6:0]       dec_segs;
    logic             blank;
    logic [3:0]       seg_n;
    logic [6:0]       code_n;
    logic             fd_n;

    // Scan sequencing: counters restart on every state change.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        case (state)
            ST_OFF: begin
                idx_n = 2'd0;
                cnt_n = '0;
                if (ENABLE) begin
                    state_n = ST_ON;
                end
            end
            ST_ON: begin
                if (!ENABLE) begin
                    state_n = ST_OFF;
                    idx_n   = 2'd0;
                    cnt_n   = '0;
                end else if (cnt == DWELL_LAST) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (!ENABLE) begin
                    state_n = ST_OFF;
                    idx_n   = 2'd0;
                    cnt_n   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_n = ST_ON;
                    idx_n   = idx + 2'd1;   // digit 3 wraps to 0
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_OFF;
                idx_n   = 2'd0;
                cnt_n   = '0;
            end
        endcase
    end

    // Load handshake. LOAD_READY mirrors an empty pending buffer, so a copy
    // and an accept can never coincide. A load taken during the FRAME_DONE
    // cycle finds pend_vld low, so it is not copied until the next boundary.
    assign accept     = LOAD_VALID & LOAD_READY;
    assign copy       = pend_vld & (FRAME_DONE | (state == ST_OFF));
    assign disp_n     = copy ? pend : disp;
    assign pend_vld_n = accept | (pend_vld & ~copy);

    // Outputs are computed from next-state values and registered, so they
    // line up with the state they describe.
    always_comb begin
        nib = disp_n[15:12];
        case (idx_n)
            2'd0:    nib = disp_n[15:12];
            2'd1:    nib = disp_n[11:8];
            2'd2:    nib = disp_n[7:4];
            default: nib = disp_n[3:0];
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd  (nib),
        .segs (dec_segs)
    );

`ifdef SEG_SCAN_LZB_EN
    // A zero digit is blanked only when every digit to its left is zero too.
    always_comb begin
        blank = 1'b0;
        case (idx_n)
            2'd0:    blank = (disp_n[15:12] == 4'd0);
            2'd1:    blank = (disp_n[15:8]  == 8'd0);
            2'd2:    blank = (disp_n[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_n  = 4'b0000;
        code_n = SEG_BLANK;
        if ((state_n == ST_ON) && !blank) begin
            seg_n  = digit_onehot(idx_n);
            code_n = dec_segs;
        end
    end

    assign fd_n = (state_n == ST_GAP) && (idx_n == LAST_DIGIT) && (cnt_n == GAP_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_OFF;
            idx        <= 2'd0;
            cnt        <= '0;
            disp       <= 16'h0000;
            pend_vld   <= 1'b0;
            SEG        <= 4'b0000;
            CODEOUT    <= SEG_BLANK;
            FRAME_DONE <= 1'b0;
            LOAD_READY <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            disp       <= disp_n;
            pend_vld   <= pend_vld_n;
            SEG        <= seg_n;
            CODEOUT    <= code_n;
            FRAME_DONE <= fd_n;
            LOAD_READY <= ~pend_vld_n;
        end
    end

    // Pending data is qualified by pend_vld, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            pend <= LOAD_DATA;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int DW = 4;
    localparam int GW = 1;

    localparam logic [6:0] C0 = 7'b1111110;
    localparam logic [6:0] C1 = 7'b0110000;
    localparam logic [6:0] C2 = 7'b1101101;
    localparam logic [6:0] C3 = 7'b1111001;
    localparam logic [6:0] C4 = 7'b0110011;
    localparam logic [6:0] C5 = 7'b1011011;
    localparam logic [6:0] C6 = 7'b1011111;
    localparam logic [6:0] C7 = 7'b1110000;
    localparam logic [6:0] C8 = 7'b1111111;
    localparam logic [6:0] C9 = 7'b1111011;
    localparam logic [6:0] CD = 7'b0000001;
    localparam logic [6:0] CB = 7'b0000000;

    logic        CLK;
    logic        RST_N;
    logic        ENABLE;
    logic        LOAD_VALID;
    logic [15:0] LOAD_DATA;
    logic        LOAD_READY;
    logic [6:0]  CODEOUT;
    logic [3:0]  SEG;
    logic        FRAME_DONE;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;
        logic [27:0] codes;   // {digit0, digit1, digit2, digit3}
        logic [15:0] segs;    // {digit0, digit1, digit2, digit3}
    } vec_t;

    vec_t vecs [6];

    seg_scan_ctrl #(
        .DWELL_CYCLES (DW),
        .GAP_CYCLES   (GW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENABLE     (ENABLE),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_DATA  (LOAD_DATA),
        .LOAD_READY (LOAD_READY),
        .CODEOUT    (CODEOUT),
        .SEG        (SEG),
        .FRAME_DONE (FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Frame row r (0..19): digit r/5; phases 0..3 are the ON slot, phase 4 the gap.
    task automatic frame_rows(input logic [27:0] codes, input logic [15:0] segs,
                              input int first, input int last, input string tag);
        int d;
        int ph;
        logic [11:0] exp;
        for (int r = first; r <= last; r++) begin
            d  = r / 5;
            ph = r % 5;
            tick;
            if (ph < 4) exp = {segs[15-4*d -: 4], codes[27-7*d -: 7], 1'b0};
            else        exp = {4'b0000, CB, (d == 3)};
            check($sformatf("%s row%0d {seg,code,fd}", tag, r), {20'd0, SEG, CODEOUT, FRAME_DONE}, {20'd0, exp});
        end
    endtask

    task automatic load_off(input logic [15:0] data);
        ENABLE = 1'b0;
        tick;
        LOAD_VALID = 1'b1;
        LOAD_DATA  = data;
        tick;
        check("ready_low_after_accept", {31'd0, LOAD_READY}, 32'd0);
        LOAD_VALID = 1'b0;
        tick;
        check("ready_high_after_off_copy", {31'd0, LOAD_READY}, 32'd1);
    endtask

    logic [27:0] f1778, f1234, f5678, f4321, fzero;
    logic [15:0] szero;

    initial begin
        RST_N      = 1'b0;
        ENABLE     = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_DATA  = 16'h0000;

        f1778 = {C1, C7, C7, C8};
        f1234 = {C1, C2, C3, C4};
        f5678 = {C5, C6, C7, C8};
        f4321 = {C4, C3, C2, C1};

        vecs[0] = '{16'h1778, {C1, C7, C7, C8}, 16'h8421};
        vecs[1] = '{16'hA0F9, {CD, C0, CD, C9}, 16'h8421};
        vecs[2] = '{16'h2365, {C2, C3, C6, C5}, 16'h8421};
`ifdef SEG_SCAN_LZB_EN
        vecs[3] = '{16'h0042, {CB, CB, C4, C2}, 16'h0021};
        vecs[4] = '{16'h0000, {CB, CB, CB, C0}, 16'h0001};
        vecs[5] = '{16'h0409, {CB, C4, C0, C9}, 16'h0421};
        fzero = {CB, CB, CB, C0};
        szero = 16'h0001;
`else
        vecs[3] = '{16'h0042, {C0, C0, C4, C2}, 16'h8421};
        vecs[4] = '{16'h0000, {C0, C0, C0, C0}, 16'h8421};
        vecs[5] = '{16'h0409, {C0, C4, C0, C9}, 16'h8421};
        fzero = {C0, C0, C0, C0};
        szero = 16'h8421;
`endif

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_seg", {28'd0, SEG}, 32'd0);
        check("rst_code", {25'd0, CODEOUT}, 32'd0);
        check("rst_fd", {31'd0, FRAME_DONE}, 32'd0);
        check("rst_ready", {31'd0, LOAD_READY}, 32'd0);
        RST_N = 1'b1;
        tick;
        check("ready_after_release", {31'd0, LOAD_READY}, 32'd1);
        check("seg_off_after_release", {28'd0, SEG}, 32'd0);

        // Table of display values, one full frame each
        for (int i = 0; i < 6; i++) begin
            load_off(vecs[i].data);
            ENABLE = 1'b1;
            frame_rows(vecs[i].codes, vecs[i].segs, 0, 19, $sformatf("vec%0d", i));
        end

        // Mid-frame load holds off a second load until the frame boundary
        load_off(16'h1778);
        ENABLE = 1'b1;
        frame_rows(f1778, 16'h8421, 0, 5, "hold_pre");
        check("ready_before_midload", {31'd0, LOAD_READY}, 32'd1);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h1234;
        frame_rows(f1778, 16'h8421, 6, 6, "hold");
        check("ready_low_after_1234", {31'd0, LOAD_READY}, 32'd0);
        LOAD_DATA = 16'h5678;
        for (int r = 7; r <= 19; r++) begin
            frame_rows(f1778, 16'h8421, r, r, "hold");
            check($sformatf("holdoff_ready row%0d", r), {31'd0, LOAD_READY}, 32'd0);
        end
        frame_rows(f1234, 16'h8421, 0, 0, "f1234");
        check("ready_after_boundary", {31'd0, LOAD_READY}, 32'd1);
        frame_rows(f1234, 16'h8421, 1, 1, "f1234");
        check("ready_low_after_5678", {31'd0, LOAD_READY}, 32'd0);
        LOAD_VALID = 1'b0;
        frame_rows(f1234, 16'h8421, 2, 19, "f1234");
        frame_rows(f5678, 16'h8421, 0, 19, "f5678");

        // Load accepted on the FRAME_DONE cycle waits one more frame
        check("fd_cycle_ready", {31'd0, LOAD_READY}, 32'd1);
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h4321;
        frame_rows(f5678, 16'h8421, 0, 0, "fdload");
        check("ready_low_after_fdload", {31'd0, LOAD_READY}, 32'd0);
        LOAD_VALID = 1'b0;
        frame_rows(f5678, 16'h8421, 1, 19, "fdload");
        frame_rows(f4321, 16'h8421, 0, 19, "f4321");

        // ENABLE low during digit 1, then restart from digit 0
        frame_rows(f4321, 16'h8421, 0, 6, "en_pre");
        ENABLE = 1'b0;
        tick;
        check("en_off_outputs", {20'd0, SEG, CODEOUT, FRAME_DONE}, 32'd0);
        tick;
        check("en_off_outputs2", {20'd0, SEG, CODEOUT, FRAME_DONE}, 32'd0);
        ENABLE = 1'b1;
        frame_rows(f4321, 16'h8421, 0, 19, "restart");

        // Asynchronous reset during digit 2 with a load pending
        frame_rows(f4321, 16'h8421, 0, 10, "rst_pre");
        LOAD_VALID = 1'b1;
        LOAD_DATA  = 16'h9999;
        frame_rows(f4321, 16'h8421, 11, 11, "rst_pre");
        LOAD_VALID = 1'b0;
        check("pending_before_reset", {31'd0, LOAD_READY}, 32'd0);
        #1;
        RST_N = 1'b0;
        #1;
        check("async_rst_seg", {28'd0, SEG}, 32'd0);
        check("async_rst_code", {25'd0, CODEOUT}, 32'd0);
        check("async_rst_ready", {31'd0, LOAD_READY}, 32'd0);
        tick;
        check("in_rst_outputs", {19'd0, SEG, CODEOUT, FRAME_DONE, LOAD_READY}, 32'd0);
        ENABLE = 1'b0;
        RST_N  = 1'b1;
        tick;
        check("ready_after_rst2", {31'd0, LOAD_READY}, 32'd1);
        check("seg_after_rst2", {28'd0, SEG}, 32'd0);
        ENABLE = 1'b1;
        frame_rows(fzero, szero, 0, 19, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 50000: clock cycles each digit is driven per visit (legal 2..2^20).
REQ-002 Parameter GAP_CYCLES, default 8: all-off cycles after each digit for anti-ghosting (legal 1..255).
REQ-003 Port CLK  input  1: sole clock, rising edge.
REQ-004 Port RST_N  input  1: reset, asynchronous assert, active-low.
REQ-005 Port ENABLE  input  1: scan enable, level.
REQ-006 Port LOAD_VALID  input  1: new display value offered.
REQ-007 Port LOAD_DATA  input  16: four BCD nibbles; [15:12] = leftmost digit.
REQ-008 Port LOAD_READY  output  1: pending buffer empty, load accepted this cycle if LOAD_VALID.
REQ-009 Port CODEOUT  output  7: segments a..g on bits 6..0, active-high.
REQ-010 Port SEG  output  4: digit select, one-hot, active-high; 4'b1000 = digit 0 (leftmost).
REQ-011 Port FRAME_DONE  output  1: one-cycle pulse at end of digit 3 gap.

Function
REQ-012 FSM states OFF, ON, GAP; all outputs registered.
REQ-013 OFF: SEG=0, CODEOUT=0, digit index=0; ENABLE=1 -> ON next edge.
REQ-014 ON: SEG one-hot for current index, CODEOUT = decode of that nibble of display register; after DWELL_CYCLES cycles -> GAP.
REQ-015 GAP: SEG=0, CODEOUT=0 for GAP_CYCLES cycles -> ON with index+1; index 3 wraps to 0.
REQ-016 Digit order 0,1,2,3 = nibbles [15:12],[11:8],[7:4],[3:0], SEG 1000,0100,0010,0001.
REQ-017 Decode: 0..9 standard (0=1111110, 1=0110000, 7=1110000, 8=1111111, 9=1111011); nibbles A..F show dash 0000001; never X.
REQ-018 Load accepted when LOAD_VALID&LOAD_READY; data stored in pending buffer; LOAD_READY deasserts next cycle.
REQ-019 Pending buffer copied to display register on the FRAME_DONE cycle, or at once if state is OFF; LOAD_READY reasserts the following cycle.
REQ-020 Display register never changes mid-frame; a frame always shows one consistent value.
REQ-021 Load accepted in the same cycle as FRAME_DONE: stays pending until next frame boundary.
REQ-022 ENABLE=0 in ON or GAP: -> OFF next edge, no FRAME_DONE; pending buffer retained.
REQ-023 Dwell and gap counters are internal-only, reset to 0 on every state change.

Reset
REQ-024 RST_N low: state OFF, index 0, counters 0, display register 16'h0000, pending empty.
REQ-025 During reset: CODEOUT=0, SEG=0, FRAME_DONE=0, LOAD_READY=0; LOAD_READY=1 first edge after release.
REQ-026 Reset mid-frame aborts immediately; no partial load survives.

Configuration
REQ-027 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking; digits 0..2 showing 0 with all left digits also 0 get SEG=0, CODEOUT=0 during their ON slot; digit 3 always shown; timing unchanged.
REQ-028 Macro undefined: every digit displayed, zeros included.

Structure
REQ-029 Package seg_pkg: segment constants for 0..9 and dash, blank constant, FSM state enum, digit count constant 4.
REQ-030 Sub-module bcd_to_7seg: combinational 4-bit to 7-bit decoder per REQ-017, instantiated once.

Verification (DWELL_CYCLES=4, GAP_CYCLES=1)
REQ-031 Reset, ENABLE=1, load 16'h1778 -> SEG 1000/0100/0010/0001 with CODEOUT 0110000/1110000/1110000/1111111, 4 cycles each, 1 gap cycle, FRAME_DONE every 20 cycles.
REQ-032 Load 16'h1234 mid-frame, then 16'h5678 offered -> second held off (LOAD_READY=0) until after FRAME_DONE; next frame shows 1234 only.
REQ-033 LOAD_DATA 16'hA0F9 -> digits dash,0,dash,9.
REQ-034 RST_N low during digit 2 ON -> outputs 0 asynchronously; after release display 0000, LOAD_READY=1.
REQ-035 ENABLE low during digit 1 -> OFF next edge, no FRAME_DONE; re-enable restarts at digit 0.
REQ-036 With SEG_SCAN_LZB_EN, load 16'h0042 -> digits 0,1 blank (SEG=0), digits 2,3 show 4,2; 16'h0000 shows only digit 3 as 0.
